// File: rtl/bcd_digit_counter.sv
// Debounced up/down push-button BCD digit (0-9) with carry/borrow pulses for cascading.
// Each raw button passes a 2-flop synchroniser and a level debouncer before edge detection.

module bcd_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Synchroniser, debounce qualification and accepted-level history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= btn;
      s2       <= s1;
      stable_d <= stable;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Only the accepted rising edge counts; a held button or a release never steps
  assign press = stable & ~stable_d;

endmodule

module bcd_digit_counter #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry,
  output logic       borrow
);

  logic       press_up;
  logic       press_down;
  logic [3:0] digit_nxt;
  logic       carry_nxt;
  logic       borrow_nxt;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

  bcd_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_up),
    .press (press_up)
  );

  bcd_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_down),
    .press (press_down)
  );

  // Step selection: clear beats enable, and simultaneous up/down presses cancel
  always_comb begin
    digit_nxt  = digit;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;
    if (clr) begin
      digit_nxt = 4'd0;
    end else if (en && !(press_up && press_down)) begin
      if (press_up) begin
        digit_nxt = bcd_inc(digit);
        carry_nxt = (digit == 4'd9);
      end else if (press_down) begin
        digit_nxt  = bcd_dec(digit);
        borrow_nxt = (digit == 4'd0);
      end
    end
  end

  // Registered digit with pulses aligned to the first cycle of the new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit  <= 4'd0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      digit  <= digit_nxt;
      carry  <= carry_nxt;
      borrow <= borrow_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Bench for bcd_digit_counter: cycle scoreboard fed by a bench-side model plus directed scenario checks.

module tb_bcd_digit_counter;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       en = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] digit;
  logic       carry;
  logic       borrow;

  int n_checks = 0;
  int n_errors = 0;
  int carry_cnt = 0;
  int borrow_cnt = 0;

  logic [5:0] exp_q[$];
  logic [5:0] exp_v;

  // Model state; index 0 = up button, 1 = down button
  logic [1:0] m_s1, m_s2, m_st, m_std, m_btn;
  int         m_cnt[2];
  logic [3:0] m_dig;
  logic       m_car, m_bor, m_pu, m_pd;

  bcd_digit_counter #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .en       (en),
    .clr      (clr),
    .digit    (digit),
    .carry    (carry),
    .borrow   (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_std = '0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_dig = 4'd0; m_car = 1'b0; m_bor = 1'b0;
      exp_q.delete();
    end else begin
      m_btn = {btn_down, btn_up};
      m_pu  = m_st[0] & ~m_std[0];
      m_pd  = m_st[1] & ~m_std[1];
      m_car = 1'b0;
      m_bor = 1'b0;
      if (clr) m_dig = 4'd0;
      else if (!en || (m_pu && m_pd)) m_dig = m_dig;
      else if (m_pu) begin
        if (m_dig == 4'd9) begin m_dig = 4'd0; m_car = 1'b1; end
        else m_dig = m_dig + 4'd1;
      end else if (m_pd) begin
        if (m_dig == 4'd0) begin m_dig = 4'd9; m_bor = 1'b1; end
        else m_dig = m_dig - 4'd1;
      end
      for (int i = 0; i < 2; i++) begin
        m_std[i] = m_st[i];
        if (m_s2[i] == m_st[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == DC - 1) begin m_st[i] = m_s2[i]; m_cnt[i] = 0; end
        else m_cnt[i]++;
        m_s2[i] = m_s1[i];
        m_s1[i] = m_btn[i];
      end
      exp_q.push_back({m_dig, m_car, m_bor});
    end
  end

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      chk("out", {digit, carry, borrow}, exp_v);
      chk("range", (digit <= 4'd9), 1);
      carry_cnt  += carry;
      borrow_cnt += borrow;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic u, input logic d, input int hold);
    btn_up = u;
    btn_down = d;
    tick(hold);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(12);
  endtask

  int c0, b0;

  initial begin
    tick(3);
    chk("rst_digit", digit, 0);
    chk("rst_carry", carry, 0);
    chk("rst_borrow", borrow, 0);
    rst_n = 1'b1;

    // Latency: first sampled at edge 1, digit changes at edge DC+3
    btn_up = 1'b1;
    for (int k = 1; k <= DC + 3; k++) begin
      tick(1);
      chk("latency", digit, (k < DC + 3) ? 0 : 1);
      chk("latency_carry", carry, 0);
    end
    btn_up = 1'b0;
    tick(12);

    for (int r = 0; r < 5; r++) begin
      btn_up = 1'b1; tick(DC - 1);
      btn_up = 1'b0; tick(1);
    end
    tick(12);
    chk("bounce", digit, 1);
    press(1'b1, 1'b0, DC);
    chk("clean", digit, 2);

    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr", digit, 0);

    c0 = carry_cnt;
    for (int i = 0; i < 10; i++) begin
      press(1'b1, 1'b0, DC);
      chk("wrap_up", digit, (i + 1) % 10);
    end
    chk("carry_pulses", carry_cnt - c0, 1);

    b0 = borrow_cnt;
    press(1'b0, 1'b1, DC);
    chk("wrap_down", digit, 9);
    chk("borrow_pulses", borrow_cnt - b0, 1);

    repeat (4) press(1'b0, 1'b1, DC);
    chk("to_five", digit, 5);
    c0 = carry_cnt; b0 = borrow_cnt;
    press(1'b1, 1'b1, DC);
    chk("simul", digit, 5);
    chk("simul_pulses", (carry_cnt - c0) + (borrow_cnt - b0), 0);

    en = 1'b0;
    press(1'b1, 1'b0, DC);
    en = 1'b1;
    tick(12);
    chk("en_low", digit, 5);

    press(1'b1, 1'b0, DC);
    press(1'b1, 1'b0, DC);
    chk("to_seven", digit, 7);
    c0 = carry_cnt;
    btn_up = 1'b1; tick(DC);
    btn_up = 1'b0; tick(2);
    clr = 1'b1; tick(1); clr = 1'b0;
    chk("clr_press", digit, 0);
    tick(12);
    chk("clr_stale", digit, 0);
    chk("clr_carry", carry_cnt - c0, 0);

    repeat (3) press(1'b1, 1'b0, DC);
    chk("to_three", digit, 3);
    btn_up = 1'b1; tick(3);
    rst_n = 1'b0; #1;
    chk("rst_mid_digit", digit, 0);
    chk("rst_mid_carry", carry, 0);
    chk("rst_mid_borrow", borrow, 0);
    btn_up = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(15);
    chk("rst_stale", digit, 0);

    btn_up = 1'b1; tick(1000);
    btn_up = 1'b0; tick(12);
    chk("long_hold", digit, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) btn_up = ~btn_up;
      if ($urandom_range(5) == 0) btn_down = ~btn_down;
      en  = ($urandom_range(7) != 0);
      clr = ($urandom_range(63) == 0);
      tick(1);
    end
    btn_up = 1'b0; btn_down = 1'b0; en = 1'b1; clr = 1'b0;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
